div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//  EX-stage front end for the 32-cycle sequential divider: accepts one RV32M DIV/DIVU/REM/REMU op at a time.
//  Holds operands stable, drives the divider's level enable and captures its done pulse.
//  Selects and sign-corrects the result, then returns it with the destination tag over valid/ready.
//  Exports busy for the hazard unit so the pipeline stalls while a division is outstanding.
// PARAMETERS
//  TAG_W    5   width of destination-register tag carried with the op
//  TIMEOUT  48  max cycles in BUSY/DRAIN before a missing div_done is flagged
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous active-low reset
//  req_valid    in   1      op offered
//  req_ready    out  1      op accepted when req_valid & req_ready
//  req_funct3   in   3      100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are illegal (never sent)
//  req_a        in   32     dividend (rs1)
//  req_b        in   32     divisor (rs2)
//  req_tag      in   TAG_W  destination tag
//  flush        in   1      kill outstanding op (branch mispredict/trap)
//  resp_valid   out  1      result available
//  resp_ready   in   1      result consumed when resp_valid & resp_ready
//  resp_data    out  32     architectural result
//  resp_tag     out  TAG_W  tag of the op that produced resp_data
//  busy         out  1      state != IDLE
//  div_timeout  out  1      sticky error, cleared only by reset
//  div_enable   out  1      to divider enable
//  div_sign_sel out  1      to divider sign_sel: 1 = unsigned, 0 = signed
//  div_a, div_b out  32     to divider numA/denB (registered)
//  div_done     in   1      divider done pulse
//  div_quo, div_rem in 32   divider quotient/remainder
// BEHAVIOUR
//  Reset values: state=IDLE, all registers 0.
//   Outputs: req_ready=1, resp_valid=0, busy=0, div_enable=0, div_timeout=0, resp_data=0, resp_tag=0.
//  States IDLE, BUSY, DRAIN, RESP:
//   IDLE: req_ready=1. On accept (no flush), register funct3, a, b, tag -> BUSY. flush in the same cycle wins: no accept.
//   BUSY: div_enable=1. On div_done: capture result -> RESP. On flush (no div_done): -> DRAIN. If flush and div_done coincide: -> IDLE, result dropped.
//   DRAIN: div_enable=0. Wait for div_done -> IDLE. No response is produced.
//   RESP: resp_valid=1 with resp_data and resp_tag stable. On resp_ready -> IDLE. On flush -> IDLE, response dropped.
//  req_ready is 1 only in IDLE; no back-to-back overlap with RESP.
//  div_a, div_b and div_sign_sel come from registers. They are held constant from the accept edge until the div_done cycle inclusive, because the divider output sign logic reads them combinationally.
//  div_sign_sel = funct3[0].
//  div_enable is low in the cycle after div_done, so the divider must not restart.
//  Latency from the accept edge to resp_valid=1:
//   Nonzero divisor: 34 cycles (div_done is high 33 cycles after BUSY entry).
//   Zero divisor: 3 cycles.
//  Result selection:
//   DIV/DIVU: resp_data = div_quo.
//   REMU: resp_data = div_rem.
//   REM: the divider signs the remainder by a^b; RISC-V requires the sign of a.
//    If b[31]=1 and b!=0: resp_data = -div_rem (32-bit two's complement).
//    Otherwise: resp_data = div_rem.
//  Corner results come out of the divider unmodified:
//   x/0 -> 0xFFFFFFFF.
//   x%0 -> x.
//   0x80000000/-1 -> 0x80000000, remainder 0.
//  Watchdog: a counter clears on entry to BUSY/DRAIN and increments each cycle there.
//   On reaching TIMEOUT without div_done: set div_timeout, go to IDLE, drop the op.
//  Reset mid-operation: async return to IDLE and drop all state.
//   The divider's synchronous active-high reset is driven from the same system reset.
// TESTING
//  DIV a=-7 b=2, resp_ready=1 -> resp_data=0xFFFFFFFD, resp_tag echoed, resp_valid 34 cycles after accept.
//  REM a=7 b=-2 -> 1; REM a=-7 b=-2 -> 0xFFFFFFFF; REMU a=0xFFFFFFFF b=16 -> 15.
//  DIVU a=5 b=0 -> 0xFFFFFFFF after 3 cycles; REM a=-5 b=0 -> 0xFFFFFFFB; DIV 0x80000000/-1 -> 0x80000000.
//  flush at BUSY cycle 10 -> busy held (DRAIN) until div_done, no resp_valid, next op accepted after IDLE and correct.
//  resp_ready low for 5 cycles -> resp_valid/data/tag stable, req_ready=0; flush in RESP -> IDLE, nothing consumed.
//  div_done forced never to arrive -> div_timeout=1 at cycle TIMEOUT, IDLE; reset_n pulse mid-BUSY -> reset values immediately.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake between the EX pipeline and the divider issue controller.
interface div_issue_ctrl_if #(
  parameter int unsigned TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_funct3, req_a, req_b, req_tag, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, req_tag, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage front end for a 32-cycle sequential divider: holds operands, sequences
// the divider, sign-corrects REM results and returns them with their tag.
module div_issue_ctrl #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 48
) (
  input  logic                clk,
  input  logic                reset_n,
  div_issue_ctrl_if.slave     bus,
  output logic                busy,
  output logic                div_timeout,
  output logic                div_enable,
  output logic                div_sign_sel,
  output logic [31:0]         div_a,
  output logic [31:0]         div_b,
  input  logic                div_done,
  input  logic [31:0]         div_quo,
  input  logic [31:0]         div_rem
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_e;

  state_e           state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;

  logic             wd_last;
  logic             is_rem;
  logic [31:0]      result;

  assign wd_last = (wd_q == WD_W'(TIMEOUT - 1));
  assign is_rem  = funct3_q[2] & funct3_q[1];

  // The divider signs the remainder by a^b; RISC-V wants the sign of the dividend,
  // which differs exactly when the signed divisor is negative.
  always_comb begin
    result = div_quo;
    if (is_rem) begin
      result = div_rem;
      if (!funct3_q[0] && b_q[31] && (b_q != '0)) begin
        result = 32'd0 - div_rem;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    data_d    = data_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          funct3_d = bus.req_funct3;
          a_d      = bus.req_a;
          b_d      = bus.req_b;
          tag_d    = bus.req_tag;
          wd_d     = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wd_d = wd_q + 1'b1;
        if (div_done && bus.flush) begin
          state_d = IDLE;
        end else if (div_done) begin
          data_d  = result;
          state_d = RESP;
        end else if (bus.flush) begin
          wd_d    = '0;
          state_d = DRAIN;
        end else if (wd_last) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (div_done) begin
          state_d = IDLE;
        end else if (wd_last) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RESP: begin
        if (bus.resp_ready || bus.flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_data  = data_q;
    bus.resp_tag   = tag_q;
    busy           = (state_q != IDLE);
    div_enable     = (state_q == BUSY);
    div_timeout    = timeout_q;
    div_sign_sel   = funct3_q[0];
    div_a          = a_q;
    div_b          = b_q;
  end

endmodule
